uart_endpoint: RTL

- Synthesizable DUT-side UART: serializes bytes onto `uart_tx` and deserializes bytes from `uart_rx`.
- It is the far end of the simulation UART bridge: its `uart_tx`, `uart_tx_driven` and `uart_rx` connect directly to the bridge's pins of the same names.
- Frame format is fixed 8N1, LSB first, with one bit period = CLKS_PER_BIT clocks.
- Byte-side interfaces are valid/ready, with a one-byte RX holding register.

---
 rtl/uart_endpoint.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_endpoint.sv
// DUT-side 8N1 UART endpoint: byte-wide valid/ready TX serializer and RX
// deserializer with a one-byte holding register, overrun and framing-error pulses.
module uart_endpoint #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       uart_tx,
   output logic       uart_tx_driven,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_overrun,
   output logic       rx_frame_err
);

   if ((CLKS_PER_BIT < 4) || ((CLKS_PER_BIT % 2) != 0)) begin : g_bad_clks_per_bit
      $error("uart_endpoint: CLKS_PER_BIT must be even and >= 4");
   end

   localparam int unsigned CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   // ---------------------------------------------------------------- TX
   tx_state_e      tx_state_q, tx_state_d;
   logic [CW-1:0]  tx_cnt_q, tx_cnt_d;
   logic [2:0]     tx_idx_q, tx_idx_d;
   logic [7:0]     tx_shift_q, tx_shift_d;
   logic           tx_out_q, tx_out_d;
   logic           driven_q;
   logic           tx_bit_end;
   logic           tx_fire;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_shift_q <= '0;
         tx_out_q   <= 1'b1;
         driven_q   <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_shift_q <= tx_shift_d;
         tx_out_q   <= tx_out_d;
         driven_q   <= 1'b1;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + CW'(1);
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_out_d   = tx_out_q;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            tx_out_d = 1'b1;
            if (tx_fire) begin
               tx_state_d = TX_START;
               tx_shift_d = tx_data;
               tx_out_d   = 1'b0;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_d = TX_DATA;
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_out_d   = tx_shift_q[0];
               tx_shift_d = tx_shift_q >> 1;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               if (tx_idx_q == 3'd7) begin
                  tx_state_d = TX_STOP;
                  tx_out_d   = 1'b1;
               end else begin
                  tx_idx_d   = tx_idx_q + 3'd1;
                  tx_out_d   = tx_shift_q[0];
                  tx_shift_d = tx_shift_q >> 1;
               end
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               tx_cnt_d = '0;
               // Accepting in the last stop cycle chains straight into the next start bit.
               if (tx_fire) begin
                  tx_state_d = TX_START;
                  tx_shift_d = tx_data;
                  tx_out_d   = 1'b0;
               end else begin
                  tx_state_d = TX_IDLE;
                  tx_out_d   = 1'b1;
               end
            end
         end
         default: begin
            tx_state_d = TX_IDLE;
            tx_out_d   = 1'b1;
         end
      endcase
   end

   always_comb begin
      tx_bit_end = (tx_cnt_q == BIT_LAST);
      tx_ready   = ((tx_state_q == TX_IDLE) && driven_q) ||
                   ((tx_state_q == TX_STOP) && tx_bit_end);
      tx_fire    = tx_valid && tx_ready;
   end

   assign uart_tx        = tx_out_q;
   assign uart_tx_driven = driven_q;

   // ---------------------------------------------------------------- RX
   rx_state_e      rx_state_q, rx_state_d;
   logic [CW-1:0]  rx_cnt_q, rx_cnt_d;
   logic [2:0]     rx_idx_q, rx_idx_d;
   logic [7:0]     rx_shift_q, rx_shift_d;
   logic           sync1_q, sync2_q, samp_q;
   logic [7:0]     rx_data_q, rx_data_d;
   logic           rx_valid_q, rx_valid_d;
   logic           overrun_q, overrun_d;
   logic           ferr_q, ferr_d;
   logic           rx_fall;
   logic           rx_bit_end;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         samp_q     <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_shift_q <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         sync1_q    <= uart_rx;
         sync2_q    <= sync1_q;
         samp_q     <= sync2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_shift_q <= rx_shift_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         overrun_q  <= overrun_d;
         ferr_q     <= ferr_d;
      end
   end

   always_comb begin
      rx_fall    = samp_q && !sync2_q;
      rx_bit_end = (rx_cnt_q == BIT_LAST);
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + CW'(1);
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_fall) begin
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            // Counter restarts at mid start bit, so later samples land mid-bit.
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d = '0;
               if (sync2_q) begin
                  rx_state_d = RX_IDLE;
               end else begin
                  rx_state_d = RX_DATA;
                  rx_idx_d   = '0;
               end
            end
         end
         RX_DATA: begin
            if (rx_bit_end) begin
               rx_cnt_d   = '0;
               rx_shift_d = {sync2_q, rx_shift_q[7:1]};
               if (rx_idx_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + 3'd1;
               end
            end
         end
         RX_STOP: begin
            if (rx_bit_end) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   logic rx_stop_hit, rx_good, rx_read, rx_load;

   always_comb begin
      rx_stop_hit = (rx_state_q == RX_STOP) && rx_bit_end;
      rx_good     = rx_stop_hit && sync2_q;
      rx_read     = rx_valid_q && rx_ready;
      rx_load     = rx_good && (!rx_valid_q || rx_read);
      rx_valid_d  = rx_load || (rx_valid_q && !rx_read);
      rx_data_d   = rx_load ? rx_shift_q : rx_data_q;
      overrun_d   = rx_good && rx_valid_q && !rx_read;
      ferr_d      = rx_stop_hit && !sync2_q;
   end

   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign rx_overrun   = overrun_q;
   assign rx_frame_err = ferr_q;

endmodule
